wgt_fifo_rd_ctrl: RTL and testbench

WGT_FIFO_RD_CTRL -- requirements
Module: wgt_fifo_rd_ctrl

---
 rtl/wgt_fifo_rd_ctrl_if.sv | 27 ++
 rtl/wgt_fifo_rd_ctrl.sv | 104 ++++++++++
 tb/tb_wgt_fifo_rd_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/wgt_fifo_rd_ctrl_if.sv
// Control/status bundle between the weight FIFO read sequencer and its user.
// The slave side is the sequencer; the master side supplies config and hold.
interface wgt_fifo_rd_ctrl_if #(
   parameter int NUM_FIFO  = 16,
   parameter int LEN_WIDTH = 13
);
   logic                  start;
   logic [4:0]            num_wgt;
   logic [LEN_WIDTH-1:0]  rd_len;
   logic [LEN_WIDTH-1:0]  num_pass;
   logic                  hold;
   logic [NUM_FIFO-1:0]   rd_en;
   logic                  rd_clr;
   logic                  busy;
   logic                  done;
   logic [LEN_WIDTH-1:0]  pass_idx;

   modport slave (
      input  start, num_wgt, rd_len, num_pass, hold,
      output rd_en, rd_clr, busy, done, pass_idx
   );

   modport master (
      output start, num_wgt, rd_len, num_pass, hold,
      input  rd_en, rd_clr, busy, done, pass_idx
   );
endinterface

// File: rtl/wgt_fifo_rd_ctrl.sv
// Weight FIFO read sequencer: rewinds all lanes, then streams rd_len words per
// lane with a one-cycle-per-lane skew, replayed num_pass times.
module wgt_fifo_rd_ctrl #(
   parameter int NUM_FIFO          = 16,
   parameter int MAX_WGT_FIFO_SIZE = 4608,
   parameter int LEN_WIDTH         = 13
) (
   input  logic              clk,
   input  logic              rst,
   wgt_fifo_rd_ctrl_if.slave bus
);
   // one extra bit so rd_len+num_wgt-1 cannot wrap at the maximum config
   localparam int TW = LEN_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_DONE} state_e;

   state_e               state_q;
   logic [4:0]           nw_q;
   logic [LEN_WIDTH-1:0] rl_q, np_q, pass_q;
   logic [TW-1:0]        t_q, t_d, run_len, t_last;
   logic                 rd_clr_q, busy_q, done_q;
   logic                 cfg_ok, last_pass, run_go;
   logic [NUM_FIFO-1:0]  rd_en;

   assign cfg_ok = (bus.num_wgt != '0)
                && (32'(bus.num_wgt) <= 32'(NUM_FIFO))
                && (bus.rd_len != '0)
                && (bus.rd_len <= LEN_WIDTH'(MAX_WGT_FIFO_SIZE))
                && (bus.num_pass != '0);

   assign run_len   = {1'b0, rl_q} + TW'(nw_q) - TW'(1);
   assign t_last    = run_len - TW'(1);
   assign t_d       = t_q + TW'(1);
   assign last_pass = ({1'b0, pass_q} + TW'(1)) >= {1'b0, np_q};
   assign run_go    = (state_q == S_RUN) && !bus.hold;

   // lane j is active for t in [j, j+rd_len-1]; a held cycle gates every lane
   for (genvar j = 0; j < NUM_FIFO; j++) begin : g_lane
      localparam logic [TW-1:0] J = TW'(j);
      assign rd_en[j] = run_go && (J < TW'(nw_q)) && (t_q >= J)
                     && ((t_q - J) < {1'b0, rl_q});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         nw_q     <= '0;
         rl_q     <= '0;
         np_q     <= '0;
         pass_q   <= '0;
         t_q      <= '0;
         rd_clr_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start && cfg_ok) begin
                  nw_q     <= bus.num_wgt;
                  rl_q     <= bus.rd_len;
                  np_q     <= bus.num_pass;
                  rd_clr_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= S_CLR;
               end
            end
            S_CLR: begin
               t_q      <= '0;
               rd_clr_q <= 1'b0;
               state_q  <= S_RUN;
            end
            S_RUN: begin
               if (!bus.hold) begin
                  if (t_q == t_last) begin
                     if (last_pass) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end else begin
                        pass_q   <= pass_q + LEN_WIDTH'(1);
                        rd_clr_q <= 1'b1;
                        state_q  <= S_CLR;
                     end
                  end else begin
                     t_q <= t_d;
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               pass_q  <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.rd_en    = rd_en;
   assign bus.rd_clr   = rd_clr_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.pass_idx = pass_q;
endmodule

// File: tb/tb_wgt_fifo_rd_ctrl.sv
// Bench for wgt_fifo_rd_ctrl: table of configs plus random sequences, each
// checked per cycle against a slot-queue reference model.
module tb_wgt_fifo_rd_ctrl;
   localparam int NF = 16;
   localparam int LW = 13;
   localparam int CYC_MAX = 12000;

   logic clk, rst;
   int n_cmp, n_err;

   wgt_fifo_rd_ctrl_if #(.NUM_FIFO(NF), .LEN_WIDTH(LW)) bus ();

   wgt_fifo_rd_ctrl #(.NUM_FIFO(NF), .MAX_WGT_FIFO_SIZE(4608), .LEN_WIDTH(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          run;
      logic [NF-1:0] rd_en;
      logic          rd_clr;
      logic          busy;
      logic          done;
      logic [LW-1:0] pass;
   } slot_t;

   typedef struct {
      int nw; int rl; int np; int hk; bit stray;
   } vec_t;

   logic [NF-1:0] log_rden [64];
   logic          log_clr  [64];
   logic          log_done [64];
   logic          log_busy [64];
   logic [LW-1:0] log_pass [64];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [NF-1:0] lane_mask(int t, int nw, int rl);
      logic [NF-1:0] m;
      m = '0;
      for (int j = 0; j < NF; j++)
         if (j < nw && t >= j && t < j + rl) m[j] = 1'b1;
      return m;
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_rd_en"}, 32'(bus.rd_en), 0);
      chk({tag, "_rd_clr"}, 32'(bus.rd_clr), 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_done"}, 32'(bus.done), 0);
      chk({tag, "_pass"}, 32'(bus.pass_idx), 0);
   endtask

   // Expected trace: one slot per CLR / non-held RUN cycle / DONE, in order.
   // A held cycle in front of a RUN slot shows a stall and consumes nothing.
   task automatic run_seq(input int nw, input int rl, input int np, input int hk, input bit stray);
      slot_t q[$];
      slot_t s, e;
      int c, tail;
      int cnt[NF];
      bit legal;
      legal = (nw >= 1) && (nw <= NF) && (rl >= 1) && (rl <= 4608) && (np >= 1);
      for (int j = 0; j < NF; j++) cnt[j] = 0;
      for (int k = 0; k < 64; k++) begin
         log_rden[k] = '0; log_clr[k] = 0; log_done[k] = 0; log_busy[k] = 0; log_pass[k] = '0;
      end
      if (legal) begin
         for (int p = 0; p < np; p++) begin
            s = '0; s.rd_clr = 1; s.busy = 1; s.pass = LW'(p);
            q.push_back(s);
            for (int t = 0; t < rl + nw - 1; t++) begin
               s = '0; s.run = 1; s.rd_en = lane_mask(t, nw, rl); s.busy = 1; s.pass = LW'(p);
               q.push_back(s);
            end
         end
         s = '0; s.busy = 1; s.done = 1; s.pass = LW'(np - 1);
         q.push_back(s);
      end
      c = 0; tail = 0;
      while (tail < 3 && c < CYC_MAX) begin
         @(posedge clk); #1;
         if (c == 0) begin
            bus.start = 1; bus.num_wgt = 5'(nw); bus.rd_len = LW'(rl); bus.num_pass = LW'(np);
         end else begin
            bus.start = stray && (q.size() > 0) && ($urandom_range(0, 3) == 0);
            if (bus.start) begin
               bus.num_wgt = 5'($urandom_range(1, 16));
               bus.rd_len = LW'($urandom_range(1, 30));
               bus.num_pass = LW'($urandom_range(1, 4));
            end
         end
         if (hk == 1)      bus.hold = (c == 4 || c == 5);
         else if (hk == 2) bus.hold = ($urandom_range(0, 9) < 3);
         else              bus.hold = 0;
         @(negedge clk);
         if (c == 0 || q.size() == 0) begin
            e = '0;
            if (c > 0) tail++;
         end else if (q[0].run && bus.hold) begin
            e = '0; e.busy = 1; e.pass = q[0].pass;
         end else begin
            e = q.pop_front();
         end
         chk("rd_en", 32'(bus.rd_en), 32'(e.rd_en));
         chk("rd_clr", 32'(bus.rd_clr), 32'(e.rd_clr));
         chk("busy", 32'(bus.busy), 32'(e.busy));
         chk("done", 32'(bus.done), 32'(e.done));
         chk("pass_idx", 32'(bus.pass_idx), 32'(e.pass));
         chk("clr_en_excl", 32'(bus.rd_clr && (|bus.rd_en)), 0);
         if (c < 64) begin
            log_rden[c] = bus.rd_en; log_clr[c] = bus.rd_clr; log_done[c] = bus.done;
            log_busy[c] = bus.busy; log_pass[c] = bus.pass_idx;
         end
         for (int j = 0; j < NF; j++) if (bus.rd_en[j] === 1'b1) cnt[j]++;
         c++;
      end
      if (c >= CYC_MAX) chk("seq_timeout", 32'(c), 0);
      for (int j = 0; j < NF; j++)
         chk("lane_pulses", 32'(cnt[j]), (legal && j < nw) ? 32'(np * rl) : 0);
      bus.start = 0; bus.hold = 0;
   endtask

   vec_t tbl[11];
   int   busy_n, done_n;

   initial begin
      n_cmp = 0; n_err = 0;
      tbl[0]  = '{3, 4, 1, 0, 0};
      tbl[1]  = '{16, 1, 2, 0, 0};
      tbl[2]  = '{3, 4, 1, 1, 0};
      tbl[3]  = '{0, 4, 1, 0, 0};
      tbl[4]  = '{3, 0, 1, 0, 0};
      tbl[5]  = '{17, 4, 1, 0, 0};
      tbl[6]  = '{3, 4, 0, 0, 0};
      tbl[7]  = '{3, 4609, 1, 0, 0};
      tbl[8]  = '{5, 6, 3, 2, 1};
      tbl[9]  = '{1, 1, 1, 0, 0};
      tbl[10] = '{16, 4608, 1, 0, 0};

      rst = 1; bus.start = 0; bus.num_wgt = '0; bus.rd_len = '0; bus.num_pass = '0; bus.hold = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle("reset");
      @(posedge clk); #1 rst = 0;

      for (int i = 0; i < 11; i++) begin
         run_seq(tbl[i].nw, tbl[i].rl, tbl[i].np, tbl[i].hk, tbl[i].stray);
         if (i == 0) begin
            chk("r30_clr_c1", 32'(log_clr[1]), 1);
            chk("r30_en_c2", 32'(log_rden[2]), 32'h0001);
            chk("r30_en_c4", 32'(log_rden[4]), 32'h0007);
            chk("r30_en_c6", 32'(log_rden[6]), 32'h0006);
            chk("r30_en_c7", 32'(log_rden[7]), 32'h0004);
            chk("r30_done_c8", 32'(log_done[8]), 1);
            busy_n = 0;
            for (int k = 0; k < 64; k++) busy_n += int'(log_busy[k]);
            chk("r30_busy_cnt", 32'(busy_n), 8);
         end
         if (i == 1) begin
            chk("r31_en_c2", 32'(log_rden[2]), 32'h0001);
            chk("r31_en_c17", 32'(log_rden[17]), 32'h8000);
            chk("r31_clr_c18", 32'(log_clr[18]), 1);
            chk("r31_pass_c18", 32'(log_pass[18]), 1);
            done_n = 0;
            for (int k = 0; k < 64; k++) done_n += int'(log_done[k]);
            chk("r31_done_cnt", 32'(done_n), 1);
         end
         if (i == 2) begin
            chk("r32_en_c4", 32'(log_rden[4]), 0);
            chk("r32_en_c5", 32'(log_rden[5]), 0);
            chk("r32_en_c6", 32'(log_rden[6]), 32'h0007);
            chk("r32_en_c8", 32'(log_rden[8]), 32'h0006);
            chk("r32_en_c9", 32'(log_rden[9]), 32'h0004);
            chk("r32_done_c10", 32'(log_done[10]), 1);
         end
      end

      for (int i = 0; i < 8; i++)
         run_seq($urandom_range(1, 16), $urandom_range(1, 12), $urandom_range(1, 3), 2, 1);
      for (int i = 0; i < 3; i++)
         run_seq(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 31), $urandom_range(1, 8), 1, 0, 0);

      // reset during the second RUN cycle, with start asserted alongside it
      @(posedge clk); #1;
      bus.start = 1; bus.num_wgt = 5'd3; bus.rd_len = LW'(4); bus.num_pass = LW'(3);
      @(posedge clk); #1 bus.start = 0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("r34_run1_en", 32'(bus.rd_en), 32'h0001);
      chk("r34_run1_busy", 32'(bus.busy), 1);
      @(posedge clk); #1;
      rst = 1; bus.start = 1; bus.hold = 1;
      @(posedge clk); #1;
      rst = 0; bus.start = 0; bus.hold = 0;
      @(negedge clk);
      chk_idle("r34_after_rst");
      @(posedge clk); #1;
      @(negedge clk);
      chk_idle("r34_still_idle");
      run_seq(2, 3, 2, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
